// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus bundle: cache CPU port, redirect strobe and decode handshake.
// The master modport is the fetch queue; the slave side is the cache/decode environment.
interface ifetch_queue_if;
    logic [31:0] ic_addr;
    logic        ic_ready;
    logic        ic_ack;
    logic [31:0] ic_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_take;
    logic        protocol_err;

    modport master (
        output ic_addr,
        input  ic_ready,
        input  ic_ack,
        input  ic_data,
        input  redirect,
        input  redirect_pc,
        output ins_valid,
        output ins_data,
        output ins_pc,
        input  ins_take,
        output protocol_err
    );

    modport slave (
        input  ic_addr,
        output ic_ready,
        output ic_ack,
        output ic_data,
        output redirect,
        output redirect_pc,
        input  ins_valid,
        input  ins_data,
        input  ins_pc,
        output ins_take,
        input  protocol_err
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: issues word addresses to the I-cache, pairs each ack with its PC,
// buffers words in a small FIFO for decode and flushes everything on a redirect.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic           clk,
    input  logic           rst,
    ifetch_queue_if.master bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          protocol_err;

    logic [31:0]   q_data [DEPTH];
    logic [31:0]   q_pc   [DEPTH];

    logic [CW:0]   occupancy;
    logic          space;
    logic          accept;
    logic          enq;
    logic          deq;
    logic          head_valid;

    // The in-flight request reserves a slot, so credit never depends on this cycle's take.
    assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign space      = occupancy < (CW+1)'(DEPTH);
    assign head_valid = (count != '0);

    assign accept = bus.ic_ready & space & ~bus.redirect;
    assign enq    = inflight & bus.ic_ack & ~bus.redirect;
    assign deq    = bus.ins_take & head_valid & ~bus.redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc    <= bus.redirect_pc;
            inflight    <= 1'b0;
        end else if (accept) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd1;
            inflight    <= 1'b1;
        end else begin
            inflight    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (bus.redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_data[wr_ptr] <= bus.ic_data;
            q_pc[wr_ptr]   <= inflight_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            protocol_err <= 1'b0;
        end else if (inflight & ~bus.ic_ack) begin
            protocol_err <= 1'b1;
        end
    end

    assign bus.ic_addr      = fetch_pc;
    assign bus.ins_valid    = head_valid;
    assign bus.ins_data     = head_valid ? q_data[rd_ptr] : 32'h0;
    assign bus.ins_pc       = head_valid ? q_pc[rd_ptr] : 32'h0;
    assign bus.protocol_err = protocol_err;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a one-cycle-latency cache model returns addr^KEY,
// and each task drives one scenario and checks hand-computed expectations.
module tb_ifetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic clk;
    logic rst;
    logic ack_q;
    logic [31:0] data_q;
    logic withhold;
    int n_cmp;
    int n_fail;

    ifetch_queue_if bus();

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache model: always hits when ready, responds one cycle later regardless of DUT credit.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q  <= 1'b0;
            data_q <= 32'h0;
        end else begin
            ack_q  <= bus.ic_ready;
            data_q <= bus.ic_addr ^ KEY;
        end
    end
    assign bus.ic_ack  = ack_q & ~withhold;
    assign bus.ic_data = data_q;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic ready, input logic take);
        rst             = 1'b1;
        bus.ic_ready    = ready;
        bus.ins_take    = take;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        withhold        = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (bus.ic_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_ic_addr got %h want 0", bus.ic_addr); end
        n_cmp++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ins_valid got %b want 0", bus.ins_valid); end
        n_cmp++; if (bus.ins_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_ins_data got %h want 0", bus.ins_data); end
        n_cmp++; if (bus.ins_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_ins_pc got %h want 0", bus.ins_pc); end
        n_cmp++; if (bus.protocol_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_protocol_err got %b want 0", bus.protocol_err); end
    endtask

    task automatic test_free_run();
        do_reset(1'b1, 1'b1);
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus.ins_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL free_valid[%0d] got %b want 1", i, bus.ins_valid); end
            n_cmp++; if (bus.ins_pc !== 32'(i)) begin n_fail++; $display("[TB] FAIL free_pc[%0d] got %h want %h", i, bus.ins_pc, 32'(i)); end
            n_cmp++; if (bus.ins_data !== (32'(i) ^ KEY)) begin n_fail++; $display("[TB] FAIL free_data[%0d] got %h want %h", i, bus.ins_data, 32'(i) ^ KEY); end
            n_cmp++; if (bus.ic_addr !== 32'(i + 2)) begin n_fail++; $display("[TB] FAIL free_ic_addr[%0d] got %h want %h", i, bus.ic_addr, 32'(i + 2)); end
            tick();
        end
    endtask

    task automatic test_stall_credit();
        logic [31:0] exp_addr [4];
        logic [31:0] exp_pc   [4];
        do_reset(1'b1, 1'b0);
        repeat (8) tick();
        n_cmp++; if (bus.ic_addr !== 32'd4) begin n_fail++; $display("[TB] FAIL stall_ic_addr got %h want 4", bus.ic_addr); end
        n_cmp++; if (bus.ins_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_valid got %b want 1", bus.ins_valid); end
        n_cmp++; if (bus.ins_pc !== 32'd0) begin n_fail++; $display("[TB] FAIL stall_pc got %h want 0", bus.ins_pc); end
        // One take, then watch exactly one extra accept.
        exp_addr = '{32'd4, 32'd5, 32'd5, 32'd5};
        bus.ins_take = 1'b1;
        tick();
        bus.ins_take = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.ic_addr !== exp_addr[i]) begin n_fail++; $display("[TB] FAIL credit_ic_addr[%0d] got %h want %h", i, bus.ic_addr, exp_addr[i]); end
            n_cmp++; if (bus.ins_pc !== 32'd1) begin n_fail++; $display("[TB] FAIL credit_pc[%0d] got %h want 1", i, bus.ins_pc); end
            if (i < 3) tick();
        end
        exp_pc = '{32'd2, 32'd3, 32'd4, 32'd5};
        bus.ins_take = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (bus.ins_pc !== exp_pc[i]) begin n_fail++; $display("[TB] FAIL drain_pc[%0d] got %h want %h", i, bus.ins_pc, exp_pc[i]); end
            n_cmp++; if (bus.ins_data !== (exp_pc[i] ^ KEY)) begin n_fail++; $display("[TB] FAIL drain_data[%0d] got %h want %h", i, bus.ins_data, exp_pc[i] ^ KEY); end
        end
    endtask

    task automatic test_miss();
        do_reset(1'b1, 1'b1);
        repeat (7) tick();
        n_cmp++; if (bus.ic_addr !== 32'd7) begin n_fail++; $display("[TB] FAIL miss_start_addr got %h want 7", bus.ic_addr); end
        bus.ic_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (bus.ic_addr !== 32'd7) begin n_fail++; $display("[TB] FAIL miss_ic_addr[%0d] got %h want 7", i, bus.ic_addr); end
        end
        n_cmp++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL miss_drained_valid got %b want 0", bus.ins_valid); end
        n_cmp++; if (bus.ins_data !== 32'h0) begin n_fail++; $display("[TB] FAIL miss_idle_data got %h want 0", bus.ins_data); end
        n_cmp++; if (bus.ins_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL miss_idle_pc got %h want 0", bus.ins_pc); end
        bus.ic_ready = 1'b1;
        tick();
        n_cmp++; if (bus.ic_addr !== 32'd8) begin n_fail++; $display("[TB] FAIL resume_ic_addr got %h want 8", bus.ic_addr); end
        n_cmp++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL resume_valid_early got %b want 0", bus.ins_valid); end
        tick();
        n_cmp++; if (bus.ins_pc !== 32'd7) begin n_fail++; $display("[TB] FAIL resume_pc0 got %h want 7", bus.ins_pc); end
        n_cmp++; if (bus.ins_data !== (32'd7 ^ KEY)) begin n_fail++; $display("[TB] FAIL resume_data0 got %h want %h", bus.ins_data, 32'd7 ^ KEY); end
        tick();
        n_cmp++; if (bus.ins_pc !== 32'd8) begin n_fail++; $display("[TB] FAIL resume_pc1 got %h want 8", bus.ins_pc); end
    endtask

    task automatic test_redirect_flush();
        do_reset(1'b1, 1'b0);
        repeat (4) tick();
        n_cmp++; if (bus.ins_pc !== 32'd0) begin n_fail++; $display("[TB] FAIL pre_redirect_pc got %h want 0", bus.ins_pc); end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        tick();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid got %b want 0", bus.ins_valid); end
        n_cmp++; if (bus.ic_addr !== 32'h100) begin n_fail++; $display("[TB] FAIL flush_ic_addr got %h want 100", bus.ic_addr); end
        tick();
        n_cmp++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stale_ack_valid got %b want 0", bus.ins_valid); end
        n_cmp++; if (bus.ic_addr !== 32'h101) begin n_fail++; $display("[TB] FAIL refetch_ic_addr got %h want 101", bus.ic_addr); end
        tick();
        n_cmp++; if (bus.ins_pc !== 32'h100) begin n_fail++; $display("[TB] FAIL redirect_pc0 got %h want 100", bus.ins_pc); end
        n_cmp++; if (bus.ins_data !== (32'h100 ^ KEY)) begin n_fail++; $display("[TB] FAIL redirect_data0 got %h want %h", bus.ins_data, 32'h100 ^ KEY); end
        bus.ins_take = 1'b1;
        tick();
        n_cmp++; if (bus.ins_pc !== 32'h101) begin n_fail++; $display("[TB] FAIL redirect_pc1 got %h want 101", bus.ins_pc); end
        tick();
        n_cmp++; if (bus.ins_pc !== 32'h102) begin n_fail++; $display("[TB] FAIL redirect_pc2 got %h want 102", bus.ins_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        do_reset(1'b1, 1'b1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFE;
        tick();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.ic_addr !== 32'hFFFF_FFFE) begin n_fail++; $display("[TB] FAIL wrap_ic_addr got %h want fffffffe", bus.ic_addr); end
        n_cmp++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_valid got %b want 0", bus.ins_valid); end
        tick(); tick();
        exp = 32'hFFFF_FFFE;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.ins_pc !== exp) begin n_fail++; $display("[TB] FAIL wrap_pc[%0d] got %h want %h", i, bus.ins_pc, exp); end
            n_cmp++; if (bus.ins_data !== (exp ^ KEY)) begin n_fail++; $display("[TB] FAIL wrap_data[%0d] got %h want %h", i, bus.ins_data, exp ^ KEY); end
            exp = exp + 32'd1;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1, 1'b1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        tick();
        bus.redirect_pc = 32'h300;
        tick();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.ic_addr !== 32'h300) begin n_fail++; $display("[TB] FAIL b2b_ic_addr got %h want 300", bus.ic_addr); end
        n_cmp++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_valid got %b want 0", bus.ins_valid); end
        tick();
        n_cmp++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_valid_r2 got %b want 0", bus.ins_valid); end
        tick();
        n_cmp++; if (bus.ins_pc !== 32'h300) begin n_fail++; $display("[TB] FAIL b2b_pc got %h want 300", bus.ins_pc); end
        n_cmp++; if (bus.ic_addr !== 32'h302) begin n_fail++; $display("[TB] FAIL b2b_next_addr got %h want 302", bus.ic_addr); end
        // Redirecting to the address already being fetched must still flush.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h302;
        tick();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL same_pc_flush_valid got %b want 0", bus.ins_valid); end
        n_cmp++; if (bus.ic_addr !== 32'h302) begin n_fail++; $display("[TB] FAIL same_pc_ic_addr got %h want 302", bus.ic_addr); end
        tick(); tick();
        n_cmp++; if (bus.ins_pc !== 32'h302) begin n_fail++; $display("[TB] FAIL same_pc_first got %h want 302", bus.ins_pc); end
    endtask

    task automatic test_protocol_err();
        do_reset(1'b1, 1'b1);
        tick();
        n_cmp++; if (bus.protocol_err !== 1'b0) begin n_fail++; $display("[TB] FAIL perr_before got %b want 0", bus.protocol_err); end
        withhold = 1'b1;
        tick();
        withhold = 1'b0;
        n_cmp++; if (bus.protocol_err !== 1'b1) begin n_fail++; $display("[TB] FAIL perr_set got %b want 1", bus.protocol_err); end
        tick();
        n_cmp++; if (bus.ins_pc !== 32'd1) begin n_fail++; $display("[TB] FAIL perr_dropped_slot_pc got %h want 1", bus.ins_pc); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.protocol_err !== 1'b1) begin n_fail++; $display("[TB] FAIL perr_sticky[%0d] got %b want 1", i, bus.protocol_err); end
            tick();
        end
        n_cmp++; if (bus.ins_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL burst_valid got %b want 1", bus.ins_valid); end
        // Mid-cycle reset: outputs must clear without a clock edge.
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.ic_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL async_ic_addr got %h want 0", bus.ic_addr); end
        n_cmp++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async_valid got %b want 0", bus.ins_valid); end
        n_cmp++; if (bus.ins_data !== 32'h0) begin n_fail++; $display("[TB] FAIL async_data got %h want 0", bus.ins_data); end
        n_cmp++; if (bus.ins_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL async_pc got %h want 0", bus.ins_pc); end
        n_cmp++; if (bus.protocol_err !== 1'b0) begin n_fail++; $display("[TB] FAIL async_perr got %b want 0", bus.protocol_err); end
        @(negedge clk);
        rst = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.ins_pc !== 32'd0) begin n_fail++; $display("[TB] FAIL post_reset_pc got %h want 0", bus.ins_pc); end
        n_cmp++; if (bus.protocol_err !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_perr got %b want 0", bus.protocol_err); end
    endtask

    initial begin
        n_cmp           = 0;
        n_fail          = 0;
        rst             = 1'b1;
        withhold        = 1'b0;
        bus.ic_ready    = 1'b0;
        bus.ins_take    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        test_reset();
        test_free_run();
        test_stall_credit();
        test_miss();
        test_redirect_flush();
        test_wrap();
        test_back_to_back();
        test_protocol_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch stage sitting directly downstream of the instruction cache's CPU port and upstream of decode. It drives the cache's word address and pairs each cache acknowledge with the PC it was issued for. It buffers fetched words in a small FIFO and presents them to decode with a valid/take handshake. On a branch redirect it flushes all queued and in-flight words and restarts fetch at the new PC.

## Interface
- `DEPTH`, 4: instruction queue entries (power of two, ≥2).
- `RESET_PC`, 32'h0: word address fetched first after reset.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ic_addr`  out  32  word address presented to the cache; cache evaluates it combinationally.
- `ic_ready`  in  1  cache hit on the current `ic_addr`; the word arrives next cycle.
- `ic_ack`  in  1  `ic_data` is valid for the address accepted in the previous cycle.
- `ic_data`  in  32  instruction word.
- `redirect`  in  1  branch/exception redirect strobe.
- `redirect_pc`  in  32  new word address, sampled when `redirect`=1.
- `ins_valid`  out  1  queue head valid.
- `ins_data`  out  32  head instruction word; 0 when `ins_valid`=0.
- `ins_pc`  out  32  head word address; 0 when `ins_valid`=0.
- `ins_take`  in  1  decode consumes the head this cycle.
- `protocol_err`  out  1  sticky; set when an expected `ic_ack` is missing.

## Operation
- State: `fetch_pc` (drives `ic_addr` directly, registered), `inflight` flag, `inflight_pc`, FIFO of {data, pc} with `count` (width clog2(DEPTH+1)), read/write pointers wrapping mod DEPTH.
- Credit: `space` = (`count` + `inflight`) < DEPTH, using registered values only. A same-cycle dequeue does not add credit.
- Accept: `accept` = `ic_ready` & `space` & !`redirect`. On accept:
  - `inflight_pc` <= `fetch_pc`
  - `fetch_pc` <= `fetch_pc`+1 (mod 2^32, wraps 32'hFFFFFFFF → 0)
  - `inflight` <= 1
- Otherwise `inflight` <= 0 and `fetch_pc` holds.
- Response: if `inflight`=1 and `ic_ack`=1 and !`redirect`, write {`ic_data`, `inflight_pc`} at the write pointer.
- An `ic_ack` with `inflight`=0 is ignored. This happens when the cache was ready but credit was lacking, or the response was squashed.
- If `inflight`=1 and `ic_ack`=0, set `protocol_err` and drop the slot. `protocol_err` clears only on reset.
- Dequeue: `ins_take` & `ins_valid` & !`redirect` advances the read pointer. `ins_take` with `ins_valid`=0 is ignored.
- Count update: +1 on enqueue only, −1 on dequeue only, unchanged on both. Enqueue into a full queue cannot occur because of the credit rule.
- Redirect, which has priority over everything:
  - `fetch_pc` <= `redirect_pc`; `count`, pointers and `inflight` <= 0.
  - No accept, enqueue or dequeue that cycle.
  - The ack arriving in the cycle after the redirect belongs to the squashed request and is dropped because `inflight`=0.
- Back-to-back redirects: the last one wins. A redirect with `redirect_pc` equal to `fetch_pc` still flushes.

## Timing
- Reset values: `ic_addr`=`RESET_PC`, `ins_valid`=0, `ins_data`=0, `ins_pc`=0, `protocol_err`=0, `count`=0, `inflight`=0.
- Reset asserted mid-fetch clears state immediately. Acks arriving after deassertion are ignored.
- Latency: accept in cycle t → enqueue at the end of t+1 → `ins_valid` high in t+2.
- After a redirect in cycle r: `ic_addr`=`redirect_pc` in r+1. The first word is visible on `ins_*` in r+3 at the earliest.
- Throughput: 1 word/cycle sustained while the cache hits and decode takes every cycle (steady `count` ≤ 2 with DEPTH=4).
- On a cache miss `ic_ready`=0: `ic_addr` holds until `ic_ready` rises, and the queue drains normally meanwhile.
- Outputs `ins_*` come straight from registers or FIFO storage with no combinational path from `ins_take`. `ic_addr` has no combinational path from any input.

## Test plan
- Reset release, `ic_ready`=1 constantly, `ins_take`=1, with cache model returning data=addr^32'hA5A5A5A5 → `ins_pc` sequence 0,1,2,… one per cycle from cycle 2. `ins_data` matches the model.
- `ins_take`=0 with cache always ready:
  - accepts stop after 4 words; `ic_addr` holds at 4.
  - Taking one word allows exactly one new accept in the following cycle.
- `ic_ready` low for 10 cycles at `ic_addr`=7 → `ic_addr` stays 7, queue drains to empty, `ins_valid`=0; fetch resumes at 7 with no gap or duplicate.
- Redirect to 32'h100 while 3 words are queued and one is in flight:
  - `ins_valid`=0 next cycle; the ack that follows is dropped.
  - First `ins_pc`=32'h100; the stale PC never appears.
- `redirect_pc`=32'hFFFFFFFE, free-run → `ins_pc` FFFFFFFE, FFFFFFFF, 0, 1.
- Model withholds `ic_ack` after an accept → `protocol_err`=1 from the next cycle, held until `rst`. Assert `rst` mid-burst → all outputs return to their reset values asynchronously.
